// File: rtl/uc_mult_pkg.sv
// Shared encodings for the shift-and-add multiplier control unit, its datapath and bench.
// Holds the FSM state constants and the Booth pair decode.
package uc_mult_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_TEST  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Booth pair {Q[0], Q[-1]}
   localparam logic [1:0] BOOTH_NOP0 = 2'b00;
   localparam logic [1:0] BOOTH_ADD  = 2'b01;
   localparam logic [1:0] BOOTH_SUB  = 2'b10;
   localparam logic [1:0] BOOTH_NOP1 = 2'b11;

   typedef struct packed {
      logic carga_a;
      logic resta_a;
   } arith_ctl_t;

   // Arithmetic strobes for one TEST cycle: plain add-if-set, or Booth add/sub/skip.
   function automatic arith_ctl_t arith_decode(input logic mode, input logic q0, input logic q_1);
      arith_ctl_t c;
      c.carga_a = 1'b0;
      c.resta_a = 1'b0;
      if (!mode) begin
         c.carga_a = q0;
      end else begin
         case ({q0, q_1})
            BOOTH_SUB: begin
               c.carga_a = 1'b1;
               c.resta_a = 1'b1;
            end
            BOOTH_ADD: c.carga_a = 1'b1;
            default: begin
               c.carga_a = 1'b0;
               c.resta_a = 1'b0;
            end
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/uc_mult_param_if.sv
// Control-unit bundle: operation request and datapath feedback in, datapath strobes and status out.
// Debug state and counter ride along so checkers can bind without reaching into the design.
interface uc_mult_param_if #(
   parameter int N  = 8,
   parameter int CW = $clog2(N + 1)
);
   // Handshake: start is a one-cycle request honoured only in IDLE or DONE; busy is high
   // from LOAD through the last SHIFT; Fin rises when A:Q holds the product and stays high
   // until the next accepted start. There is no back-pressure: every strobe is single-cycle.
   logic          start;
   logic          signed_mode;
   logic          q0;
   logic          q_1;
   logic          CargaQ;
   logic          ResetA;
   logic          CargaA;
   logic          RestaA;
   logic          DesplazaQ;
   logic          Arit;
   logic          busy;
   logic          Fin;
   logic [2:0]    state;
   logic [CW-1:0] cnt;

   modport master (
      output start, signed_mode, q0, q_1,
      input  CargaQ, ResetA, CargaA, RestaA, DesplazaQ, Arit, busy, Fin, state, cnt
   );

   modport slave (
      input  start, signed_mode, q0, q_1,
      output CargaQ, ResetA, CargaA, RestaA, DesplazaQ, Arit, busy, Fin, state, cnt
   );

endinterface

// File: rtl/uc_iter_counter.sv
// Iteration down counter: loads N at the start of an operation, steps once per shift.
// last flags the final iteration; the counter saturates at zero rather than wrapping.
module uc_iter_counter #(
   parameter int N  = 8,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [CW-1:0] LOAD_VAL = CW'(N);
   localparam logic [CW-1:0] ONE      = CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   assign last = (cnt == ONE);

endmodule

// File: rtl/uc_mult_param.sv
// Control unit for an N-bit sequential multiplier: unsigned shift-add or radix-2 Booth.
// Drives only datapath strobes; outputs decode from state, with CargaA/RestaA also using q0/q_1 in TEST.
module uc_mult_param
   import uc_mult_pkg::*;
#(
   parameter int N  = 8,
   parameter int CW = $clog2(N + 1)
) (
   input logic            clk,
   input logic            rst_n,
   uc_mult_param_if.slave bus
);

   logic [2:0]    state_r;
   logic [2:0]    state_nx;
   logic          mode_r;
   logic [CW-1:0] cnt;
   logic          cnt_last;
   logic          cnt_load;
   logic          cnt_dec;
   arith_ctl_t    arith;

   uc_iter_counter #(.N(N), .CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .cnt   (cnt),
      .last  (cnt_last)
   );

   assign cnt_load = (state_r == S_LOAD);
   assign cnt_dec  = (state_r == S_SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Mode is captured once per operation so mid-operation changes cannot mix add and Booth steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r <= 1'b0;
      end else if (state_r == S_LOAD) begin
         mode_r <= bus.signed_mode;
      end
   end

   always_comb begin
      state_nx = S_IDLE;
      case (state_r)
         S_IDLE:  state_nx = bus.start ? S_LOAD : S_IDLE;
         S_LOAD:  state_nx = S_TEST;
         S_TEST:  state_nx = S_SHIFT;
         S_SHIFT: state_nx = cnt_last ? S_DONE : S_TEST;
         S_DONE:  state_nx = bus.start ? S_LOAD : S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign arith = arith_decode(mode_r, bus.q0, bus.q_1);

   always_comb begin
      bus.CargaQ    = 1'b0;
      bus.ResetA    = 1'b0;
      bus.CargaA    = 1'b0;
      bus.RestaA    = 1'b0;
      bus.DesplazaQ = 1'b0;
      bus.busy      = 1'b0;
      bus.Fin       = 1'b0;
      case (state_r)
         S_LOAD: begin
            bus.CargaQ = 1'b1;
            bus.ResetA = 1'b1;
            bus.busy   = 1'b1;
         end
         S_TEST: begin
            bus.CargaA = arith.carga_a;
            bus.RestaA = arith.resta_a;
            bus.busy   = 1'b1;
         end
         S_SHIFT: begin
            bus.DesplazaQ = 1'b1;
            bus.busy      = 1'b1;
         end
         S_DONE:  bus.Fin = 1'b1;
         default: bus.Fin = 1'b0;
      endcase
   end

   assign bus.Arit  = mode_r;
   assign bus.state = state_r;
   assign bus.cnt   = cnt;

endmodule

// File: tb/tb_uc_mult_param.sv
// Bench for uc_mult_param: N=8 and N=4 instances, each beside a small A:Q datapath model.
// Drivers push expected strobe patterns and products; monitors pop and compare as the DUT presents them.
module tb_uc_mult_param;
   import uc_mult_pkg::*;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_fail;

   uc_mult_param_if #(.N(8)) bus8 ();
   uc_mult_param_if #(.N(4)) bus4 ();

   uc_mult_param #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   uc_mult_param #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] outs8();
      return {24'd0, bus8.CargaQ, bus8.ResetA, bus8.CargaA, bus8.RestaA,
              bus8.DesplazaQ, bus8.Arit, bus8.busy, bus8.Fin};
   endfunction

   function automatic logic [31:0] outs4();
      return {24'd0, bus4.CargaQ, bus4.ResetA, bus4.CargaA, bus4.RestaA,
              bus4.DesplazaQ, bus4.Arit, bus4.busy, bus4.Fin};
   endfunction

   // ---------------- datapath models ----------------
   logic [7:0] a8, q8, m8, mult8;
   logic       qm8, c8;
   logic [3:0] a4, q4, m4, mult4;
   logic       qm4, c4;

   always @(posedge clk) begin
      if (bus8.CargaQ) q8 <= mult8;
      if (bus8.ResetA) begin
         a8  <= 8'd0;
         qm8 <= 1'b0;
         c8  <= 1'b0;
      end
      if (bus8.CargaA) {c8, a8} <= bus8.RestaA ? ({1'b0, a8} - {1'b0, m8}) : ({1'b0, a8} + {1'b0, m8});
      if (bus8.DesplazaQ) begin
         {a8, q8, qm8} <= {(bus8.Arit ? a8[7] : c8), a8, q8};
         c8 <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (bus4.CargaQ) q4 <= mult4;
      if (bus4.ResetA) begin
         a4  <= 4'd0;
         qm4 <= 1'b0;
         c4  <= 1'b0;
      end
      if (bus4.CargaA) {c4, a4} <= bus4.RestaA ? ({1'b0, a4} - {1'b0, m4}) : ({1'b0, a4} + {1'b0, m4});
      if (bus4.DesplazaQ) begin
         {a4, q4, qm4} <= {(bus4.Arit ? a4[3] : c4), a4, q4};
         c4 <= 1'b0;
      end
   end

   assign bus8.q0  = q8[0];
   assign bus8.q_1 = qm8;
   assign bus4.q0  = q4[0];
   assign bus4.q_1 = qm4;

   // ---------------- scoreboard queues ----------------
   logic [1:0]  ctl8_q[$];
   logic [15:0] res8_q[$];
   logic        ar8_q[$];
   int          st8_q[$];
   logic [1:0]  ctl4_q[$];
   logic [7:0]  res4_q[$];
   logic        ar4_q[$];
   int          st4_q[$];

   logic mon_en8;
   logic fin8_prev, fin4_prev;
   int   sh8, sh4;

   // ---------------- monitors ----------------
   // A TEST cycle is the busy cycle with neither the load nor the shift strobe.
   always @(negedge clk) begin : mon8
      logic [1:0] e;
      if (rst_n && mon_en8) begin
         if (bus8.busy && !bus8.CargaQ && !bus8.DesplazaQ) begin
            if (ctl8_q.size() == 0) chk("ctl8_unexpected", 32'd1, 32'd0);
            else begin
               e = ctl8_q.pop_front();
               chk("ctl8", {30'd0, bus8.CargaA, bus8.RestaA}, {30'd0, e});
            end
         end
         if (bus8.CargaQ) sh8 = 0;
         if (bus8.DesplazaQ) begin
            sh8++;
            if (ar8_q.size() > 0) chk("arit8", {31'd0, bus8.Arit}, {31'd0, ar8_q[0]});
         end
         if (bus8.Fin && !fin8_prev) begin
            if (res8_q.size() == 0) chk("fin8_unexpected", 32'd1, 32'd0);
            else begin
               chk("prod8", {16'd0, a8, q8}, {16'd0, res8_q.pop_front()});
               // Cycle after edge k counts as cycle k+1, so DONE is cycle k+2N+2.
               chk("lat8", 32'(cyc - st8_q.pop_front() + 1), 32'd18);
               chk("shifts8", 32'(sh8), 32'd8);
               void'(ar8_q.pop_front());
            end
         end
      end
      fin8_prev = bus8.Fin;
   end

   always @(negedge clk) begin : mon4
      logic [1:0] e;
      if (rst_n) begin
         if (bus4.busy && !bus4.CargaQ && !bus4.DesplazaQ) begin
            if (ctl4_q.size() == 0) chk("ctl4_unexpected", 32'd1, 32'd0);
            else begin
               e = ctl4_q.pop_front();
               chk("ctl4", {30'd0, bus4.CargaA, bus4.RestaA}, {30'd0, e});
            end
         end
         if (bus4.CargaQ) sh4 = 0;
         if (bus4.DesplazaQ) begin
            sh4++;
            chk("cnt4_range", {31'd0, (bus4.cnt >= 3'd1) && (bus4.cnt <= 3'd4)}, 32'd1);
            if (ar4_q.size() > 0) chk("arit4", {31'd0, bus4.Arit}, {31'd0, ar4_q[0]});
         end
         if (bus4.Fin && !fin4_prev) begin
            if (res4_q.size() == 0) chk("fin4_unexpected", 32'd1, 32'd0);
            else begin
               chk("prod4", {24'd0, a4, q4}, {24'd0, res4_q.pop_front()});
               chk("lat4", 32'(cyc - st4_q.pop_front() + 1), 32'd10);
               chk("shifts4", 32'(sh4), 32'd4);
               chk("cnt4_end", {29'd0, bus4.cnt}, 32'd0);
               void'(ar4_q.pop_front());
            end
         end
      end
      fin4_prev = bus4.Fin;
   end

   // ---------------- drivers ----------------
   // ctl lists {CargaA,RestaA} per TEST cycle, first TEST in the most significant pair.
   task automatic op8(input logic mode, input logic [7:0] mult, input logic [7:0] m,
                      input logic [15:0] prod, input logic [15:0] ctl);
      @(negedge clk);
      mult8 = mult;
      m8    = m;
      bus8.signed_mode = mode;
      bus8.start = 1'b1;
      for (int i = 0; i < 8; i++) ctl8_q.push_back(ctl[15-2*i -: 2]);
      res8_q.push_back(prod);
      ar8_q.push_back(mode);
      st8_q.push_back(cyc + 1);
      @(negedge clk);
      bus8.start = 1'b0;
   endtask

   task automatic op4(input logic mode, input logic [3:0] mult, input logic [3:0] m,
                      input logic [7:0] prod, input logic [7:0] ctl);
      @(negedge clk);
      mult4 = mult;
      m4    = m;
      bus4.signed_mode = mode;
      bus4.start = 1'b1;
      for (int i = 0; i < 4; i++) ctl4_q.push_back(ctl[7-2*i -: 2]);
      res4_q.push_back(prod);
      ar4_q.push_back(mode);
      st4_q.push_back(cyc + 1);
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   task automatic wait_done8(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         #1;
         if (res8_q.size() == 0) return;
      end
      chk("timeout8", 32'd0, 32'd1);
      res8_q.delete();
      ctl8_q.delete();
      ar8_q.delete();
      st8_q.delete();
   endtask

   task automatic wait_done4(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         #1;
         if (res4_q.size() == 0) return;
      end
      chk("timeout4", 32'd0, 32'd1);
      res4_q.delete();
      ctl4_q.delete();
      ar4_q.delete();
      st4_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      logic fin_seen;
      n_cmp = 0;
      n_fail = 0;
      mon_en8 = 1'b1;
      fin8_prev = 1'b0;
      fin4_prev = 1'b0;
      sh8 = 0;
      sh4 = 0;
      mult8 = 8'd0;
      m8 = 8'd0;
      mult4 = 4'd0;
      m4 = 4'd0;
      rst_n = 1'b0;
      bus8.start = 1'b1;
      bus8.signed_mode = 1'b1;
      bus4.start = 1'b1;
      bus4.signed_mode = 1'b1;

      // Reset held with start high: everything quiet.
      repeat (3) @(negedge clk);
      chk("rst_outs8", outs8(), 32'd0);
      chk("rst_state8", {29'd0, bus8.state}, {29'd0, S_IDLE});
      chk("rst_outs4", outs4(), 32'd0);
      chk("rst_cnt8", {28'd0, bus8.cnt}, 32'd0);
      bus8.start = 1'b0;
      bus4.start = 1'b0;
      bus8.signed_mode = 1'b0;
      bus4.signed_mode = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_state8", {29'd0, bus8.state}, {29'd0, S_IDLE});
      chk("idle_outs8", outs8(), 32'd0);

      // Unsigned 0xA5 * 0x3C.
      op8(1'b0, 8'hA5, 8'h3C, 16'h26AC, 16'b10_00_10_00_00_10_00_10);
      wait_done8(40);

      // Unsigned 0x81 * 0xFF, with a stray start (and mode flip) in cycle 5.
      op8(1'b0, 8'h81, 8'hFF, 16'h807F, 16'b10_00_00_00_00_00_00_10);
      repeat (4) @(negedge clk);
      bus8.start = 1'b1;
      bus8.signed_mode = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      wait_done8(40);

      // Restart straight from DONE: signed 5 * -3.
      op8(1'b1, 8'h05, 8'hFD, 16'hFFF1, 16'b11_10_11_10_00_00_00_00);
      chk("restart_fin", {31'd0, bus8.Fin}, 32'd0);
      chk("restart_busy", {31'd0, bus8.busy}, 32'd1);
      chk("restart_load", {31'd0, bus8.CargaQ}, 32'd1);
      wait_done8(40);

      // Signed -6 * 7.
      op8(1'b1, 8'hFA, 8'h07, 16'hFFD6, 16'b00_11_10_11_00_00_00_00);
      wait_done8(40);

      // Abort in cycle 7: reset takes effect between edges, no Fin afterwards.
      mon_en8 = 1'b0;
      @(negedge clk);
      mult8 = 8'h0F;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outs8", outs8(), 32'd0);
      chk("abort_state8", {29'd0, bus8.state}, {29'd0, S_IDLE});
      @(negedge clk);
      rst_n = 1'b1;
      fin_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus8.Fin) fin_seen = 1'b1;
      end
      chk("abort_no_fin", {31'd0, fin_seen}, 32'd0);
      chk("abort_idle8", {29'd0, bus8.state}, {29'd0, S_IDLE});
      mon_en8 = 1'b1;

      // Recovery after abort.
      op8(1'b0, 8'hA5, 8'h3C, 16'h26AC, 16'b10_00_10_00_00_10_00_10);
      wait_done8(40);

      // N = 4 instance: unsigned 11 * 6, then signed -3 * 5.
      op4(1'b0, 4'hB, 4'h6, 8'h42, 8'b10_10_00_10);
      wait_done4(30);
      op4(1'b1, 4'hD, 4'h5, 8'hF1, 8'b11_10_11_00);
      wait_done4(30);

      repeat (2) @(negedge clk);
      chk("drain_ctl8", 32'(ctl8_q.size()), 32'd0);
      chk("drain_ctl4", 32'(ctl4_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
